// File: rtl/noc_pkg.sv
// Shared types and helpers for the mesh router input stage: flit type codes,
// port indices, flit field widths and the XY routing decision.
package noc_pkg;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_t;

    localparam int N_PORTS = 5;
    localparam int PORT_W  = 3;
    localparam int TYPE_W  = 2;

    localparam logic [PORT_W-1:0] P_LOCAL = 3'd0;
    localparam logic [PORT_W-1:0] P_NORTH = 3'd1;
    localparam logic [PORT_W-1:0] P_EAST  = 3'd2;
    localparam logic [PORT_W-1:0] P_SOUTH = 3'd3;
    localparam logic [PORT_W-1:0] P_WEST  = 3'd4;

    // X is resolved fully before Y, which keeps mesh routing deadlock-free.
    function automatic logic [PORT_W-1:0] route_xy(
        input logic x_gt,
        input logic x_lt,
        input logic y_gt,
        input logic y_lt
    );
        if (x_gt)      return P_EAST;
        else if (x_lt) return P_WEST;
        else if (y_gt) return P_NORTH;
        else if (y_lt) return P_SOUTH;
        else           return P_LOCAL;
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous FIFO; read data is the combinational head, zero read latency.
// Push is ignored when full (even with a same-cycle pop), pop ignored when empty.
module noc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH[AW:0]);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/noc_input_port.sv
// Router input port: buffers flits, XY-routes each head flit and holds a one-hot request
// for the whole packet; req rises two cycles after the head is pushed; in_ready = !full.
module noc_input_port
    import noc_pkg::*;
#(
    parameter int PAYLOAD_W = 32,
    parameter int COORD_W   = 2,
    parameter int DEPTH     = 4,
    parameter int LOCAL_X   = 0,
    parameter int LOCAL_Y   = 0,
    localparam int FLIT_W   = TYPE_W + 2*COORD_W + PAYLOAD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N_PORTS-1:0] req,
    input  logic [N_PORTS-1:0] gnt,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    output logic              err
);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    localparam logic [COORD_W-1:0] LX = LOCAL_X[COORD_W-1:0];
    localparam logic [COORD_W-1:0] LY = LOCAL_Y[COORD_W-1:0];

    logic [0:0]         state;
    logic [PORT_W-1:0]  route;
    logic               err_q;
    logic               full;
    logic               empty;
    logic               pop;
    logic               xfer;
    logic [FLIT_W-1:0]  head;
    flit_type_t         head_type;
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
    logic               is_head;
    logic               is_tail;

    noc_fifo #(
        .WIDTH(FLIT_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (in_valid && !full),
        .wdata(in_flit),
        .pop  (pop),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

    assign head_type = flit_type_t'(head[FLIT_W-1 -: TYPE_W]);
    assign dst_x     = head[FLIT_W-TYPE_W-1 -: COORD_W];
    assign dst_y     = head[FLIT_W-TYPE_W-COORD_W-1 -: COORD_W];
    assign is_head   = (head_type == FT_HEAD) || (head_type == FT_SINGLE);
    assign is_tail   = (head_type == FT_TAIL) || (head_type == FT_SINGLE);

    assign xfer = (state == S_ACTIVE) && !empty && gnt[route];
    // Orphan BODY/TAIL flits at the head while idle are discarded so the port cannot wedge.
    assign pop  = xfer || ((state == S_IDLE) && !empty && !is_head);

    assign in_ready  = !full;
    assign out_flit  = head;
    assign out_valid = (state == S_ACTIVE) && !empty;
    assign req       = (state == S_ACTIVE) ? (N_PORTS'(1) << route) : '0;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            route <= P_LOCAL;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        if (is_head) begin
                            route <= route_xy(dst_x > LX, dst_x < LX, dst_y > LY, dst_y < LY);
                            state <= S_ACTIVE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (xfer && is_tail) state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_input_port.sv
// Directed bench for noc_input_port with LOCAL=(1,1), DEPTH=4.
module tb_noc_input_port;
    localparam int PAYLOAD_W = 32;
    localparam int COORD_W   = 2;
    localparam int FLIT_W    = 2 + 2*COORD_W + PAYLOAD_W;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic              clk = 1'b0;
    logic              rst;
    logic [FLIT_W-1:0] in_flit;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        req;
    logic [4:0]        gnt;
    logic [FLIT_W-1:0] out_flit;
    logic              out_valid;
    logic              err;

    logic              follow;
    logic [4:0]        gnt_man;
    logic [FLIT_W-1:0] popped [$];
    logic [FLIT_W-1:0] sent   [$];

    int checks = 0;
    int errors = 0;

    assign gnt = follow ? req : gnt_man;

    always #5 clk = ~clk;

    noc_input_port #(
        .PAYLOAD_W(PAYLOAD_W),
        .COORD_W  (COORD_W),
        .DEPTH    (4),
        .LOCAL_X  (1),
        .LOCAL_Y  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_flit  (in_flit),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .req      (req),
        .gnt      (gnt),
        .out_flit (out_flit),
        .out_valid(out_valid),
        .err      (err)
    );

    // Record every flit handed to the crossbar.
    always @(posedge clk) begin
        if (!rst && out_valid && ((gnt & req) != 5'b0)) popped.push_back(out_flit);
    end

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [1:0] x,
                                             input logic [1:0] y, input logic [31:0] p);
        return {t, x, y, p};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_flit(input logic [FLIT_W-1:0] f);
        in_flit  = f;
        in_valid = 1'b1;
        sent.push_back(f);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_count"}, 64'(popped.size()), 64'(sent.size()));
        for (int i = 0; i < sent.size() && i < popped.size(); i++)
            chk({tag, "_flit"}, 64'(popped[i]), 64'(sent[i]));
        popped.delete();
        sent.delete();
    endtask

    initial begin
        rst = 1'b1; in_flit = '0; in_valid = 1'b0; follow = 1'b0; gnt_man = 5'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_req", 64'(req), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_err", 64'(err), 64'h0);

        // SINGLE to (3,1): east, granted immediately.
        follow = 1'b1;
        push_flit(mk(T_SINGLE, 2'd3, 2'd1, 32'hA5));
        chk("single_decode_req", 64'(req), 64'h0);
        tick();
        chk("single_req", 64'(req), 64'b00100);
        chk("single_out_valid", 64'(out_valid), 64'h1);
        tick();
        chk("single_req_fall", 64'(req), 64'h0);
        chk("single_out_valid_fall", 64'(out_valid), 64'h0);
        chk_stream("single");
        follow = 1'b0;

        // HEAD(1,0)+BODY+TAIL: south, grant withheld then held.
        push_flit(mk(T_HEAD, 2'd1, 2'd0, 32'h11));
        push_flit(mk(T_BODY, 2'd0, 2'd0, 32'h22));
        push_flit(mk(T_TAIL, 2'd0, 2'd0, 32'h33));
        for (int i = 0; i < 3; i++) begin
            chk("south_wait_req", 64'(req), 64'b01000);
            tick();
        end
        gnt_man = 5'b01000;
        tick();
        chk("south_req_pop1", 64'(req), 64'b01000);
        tick();
        chk("south_req_pop2", 64'(req), 64'b01000);
        tick();
        chk("south_req_done", 64'(req), 64'h0);
        gnt_man = 5'b0;
        chk_stream("south");
        tick();

        // Fill to DEPTH toward west; a fifth flit during the full+pop cycle is refused.
        push_flit(mk(T_HEAD, 2'd0, 2'd1, 32'h100));
        push_flit(mk(T_BODY, 2'd0, 2'd0, 32'h101));
        push_flit(mk(T_BODY, 2'd0, 2'd0, 32'h102));
        push_flit(mk(T_TAIL, 2'd0, 2'd0, 32'h103));
        chk("full_in_ready", 64'(in_ready), 64'h0);
        chk("full_req", 64'(req), 64'b10000);
        in_flit = mk(T_BODY, 2'd0, 2'd0, 32'h55);
        in_valid = 1'b1;
        gnt_man = 5'b10111;
        tick();
        in_valid = 1'b0;
        chk("full_pop_in_ready", 64'(in_ready), 64'h1);
        tick();
        tick();
        tick();
        chk("full_drain_req", 64'(req), 64'h0);
        chk("full_drain_out_valid", 64'(out_valid), 64'h0);
        gnt_man = 5'b0;
        chk_stream("full");
        tick();

        // Orphan BODY while idle: dropped with a one-cycle err.
        in_flit = mk(T_BODY, 2'd2, 2'd2, 32'h77);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("orphan_decode_err", 64'(err), 64'h0);
        tick();
        chk("orphan_err", 64'(err), 64'h1);
        chk("orphan_req", 64'(req), 64'h0);
        chk("orphan_out_valid", 64'(out_valid), 64'h0);
        tick();
        chk("orphan_err_fall", 64'(err), 64'h0);
        chk("orphan_in_ready", 64'(in_ready), 64'h1);
        follow = 1'b1;
        push_flit(mk(T_SINGLE, 2'd1, 2'd1, 32'hBEEF));
        tick();
        chk("after_orphan_req", 64'(req), 64'b00001);
        tick();
        chk("after_orphan_req_fall", 64'(req), 64'h0);
        chk_stream("after_orphan");
        follow = 1'b0;

        // Reset mid-packet with two flits buffered, heading north.
        push_flit(mk(T_HEAD, 2'd1, 2'd3, 32'h200));
        push_flit(mk(T_BODY, 2'd0, 2'd0, 32'h201));
        chk("midrst_req_before", 64'(req), 64'b00010);
        chk("midrst_out_valid_before", 64'(out_valid), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_req", 64'(req), 64'h0);
        chk("midrst_out_valid", 64'(out_valid), 64'h0);
        chk("midrst_in_ready", 64'(in_ready), 64'h1);
        tick();
        chk("midrst_still_idle", 64'(req), 64'h0);
        chk("midrst_empty", 64'(out_valid), 64'h0);
        chk("midrst_no_pops", 64'(popped.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
